// File: rtl/exp_arb_pkg.sv
// exp_arb_pkg: shared types and sizing helpers for the exponent-unit arbiter.
package exp_arb_pkg;
  localparam int W_DEF = 32;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/exp_rr_picker.sv
// exp_rr_picker: combinational round-robin pick of the first valid requester after last_grant.
module exp_rr_picker
  import exp_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    // Scan farthest-first so the nearest valid requester after last_grant wins.
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_valid[(int'(last_grant) + i) % N_REQ]) begin
        grant_idx = ID_W'((int'(last_grant) + i) % N_REQ);
        any = 1'b1;
      end
    end
    grant_onehot = any ? N_REQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin sequencer sharing one exponent unit among N_REQ requesters.
// Optional EXP_ARB_BYPASS_EN answers trivial jobs (a==0, x==0, x==1) without the unit.
module exp_arbiter
  import exp_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_x,
  input  logic [N_REQ*W-1:0]       req_a,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [id_w(N_REQ)-1:0]   rsp_id,
  output logic [W-1:0]             rsp_p,
  output logic                     busy,
  output logic                     exp_enable,
  output logic [W-1:0]             exp_x,
  output logic [W-1:0]             exp_a,
  input  logic [W-1:0]             exp_p,
  input  logic                     exp_ready
);
  localparam int ID_W = id_w(N_REQ);
  state_t state;
  logic [ID_W-1:0] last_grant, grant_idx;
  logic [N_REQ-1:0] grant_onehot;
  logic any, trivial, accept;
  logic [W-1:0] sel_x, sel_a;
  exp_rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
    .req_valid(req_valid),
    .last_grant(last_grant),
    .grant_onehot(grant_onehot),
    .grant_idx(grant_idx),
    .any(any)
  );
  assign sel_x = req_x[grant_idx*W +: W];
  assign sel_a = req_a[grant_idx*W +: W];
`ifdef EXP_ARB_BYPASS_EN
  assign trivial = sel_a == '0 || sel_x <= W'(1);
`else
  assign trivial = 1'b0;
`endif
  assign accept = reset_n && state == S_IDLE && any && (exp_ready || trivial);
  assign req_ready = accept ? grant_onehot : '0;
  assign exp_enable = state == S_ISSUE;
  assign rsp_valid = state == S_RESP;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      exp_x <= '0;
      exp_a <= '0;
      rsp_p <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      exp_x <= sel_x;
      exp_a <= sel_a;
      state <= trivial ? S_RESP : S_ISSUE;
      if (trivial) begin
        rsp_p <= sel_a == '0 ? W'(1) : sel_x;
        rsp_id <= grant_idx;
      end
    end else if (state == S_ISSUE) begin
      state <= S_BUSY;
    end else if (state == S_BUSY && exp_ready) begin
      // The unit drops p back to 1 a cycle after raising ready, so grab it now.
      rsp_p <= exp_p;
      rsp_id <= last_grant;
      state <= S_RESP;
    end else if (state == S_RESP) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: directed bench for exp_arbiter with a behavioural exponent unit model.
module tb_exp_arbiter;
  localparam int N = 4;
`ifdef EXP_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    int id;
    logic [31:0] x;
    logic [31:0] a;
    logic [31:0] p;
    int lat;
    int en;
  } vec_t;
  logic clock = 1'b0, reset_n = 1'b0, stub = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*32-1:0] req_x = '0, req_a = '0;
  logic rsp_valid, busy, exp_enable, exp_ready;
  logic [1:0] rsp_id;
  logic [31:0] rsp_p, exp_x, exp_a, exp_p;
  logic u_ready, u_run, u_done, prev_en;
  logic [31:0] u_p, u_res;
  int u_cnt, cyc = 0, en_cnt = 0, tests = 0, fails = 0;
  vec_t vecs[7];

  exp_arbiter #(.N_REQ(N), .W(32)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_x(req_x), .req_a(req_a),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy),
    .exp_enable(exp_enable), .exp_x(exp_x), .exp_a(exp_a), .exp_p(exp_p), .exp_ready(exp_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
    logic [31:0] r = 32'd1;
    logic [31:0] b = x;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) r = r * b;
      b = b * b;
    end
    return r;
  endfunction

  // Unit model: ready low for a+2 cycles after enable, then one DONE cycle holding p.
  always @(posedge clock) begin
    if (!reset_n) begin
      u_ready <= 1'b0; u_run <= 1'b0; u_done <= 1'b0; u_p <= 32'd1; u_cnt <= 0; u_res <= 32'd1;
    end else if (exp_enable) begin
      u_ready <= 1'b0; u_run <= 1'b1; u_done <= 1'b0; u_cnt <= int'(exp_a) + 1; u_res <= pow32(exp_x, exp_a);
    end else if (u_run) begin
      if (u_cnt == 0) begin
        u_run <= 1'b0; u_ready <= 1'b1; u_p <= u_res; u_done <= 1'b1;
      end else u_cnt <= u_cnt - 1;
    end else begin
      u_ready <= 1'b1;
      if (u_done) begin u_p <= 32'd1; u_done <= 1'b0; end
    end
  end
  assign exp_ready = stub ? 1'b0 : u_ready;
  assign exp_p = u_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && exp_enable) begin
      en_cnt++;
      check("enable_unit_idle", {u_ready, u_done, prev_en}, 3'b100);
    end
    prev_en <= reset_n && exp_enable;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] x, input logic [31:0] a);
    req_x[id*32 +: 32] = x;
    req_a[id*32 +: 32] = a;
    req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {60'd0, req_ready}, 64'd0);
    check({tag, "_ctl"}, {rsp_valid, busy, exp_enable}, 3'b000);
    check({tag, "_ops"}, {exp_x, exp_a}, 64'd0);
    check({tag, "_rsp"}, {30'd0, rsp_id, rsp_p}, 64'd0);
  endtask

  task automatic run_job(input vec_t v);
    int g = 0, e0;
    bit got = 1'b0, seen = 1'b0;
    set_req(v.id, v.x, v.a);
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (req_ready[v.id]) begin got = 1'b1; g = cyc; end
      step();
    end
    req_valid[v.id] = 1'b0;
    e0 = en_cnt;
    check("accept", got, 1'b1);
    for (int k = 0; k < 100 && !seen; k++) begin
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        check("latency", cyc - g, v.lat);
        check("rsp_id", rsp_id, v.id);
        check("rsp_p", rsp_p, v.p);
      end
      step();
    end
    check("rsp_seen", seen, 1'b1);
    check("enable_count", en_cnt - e0, v.en);
  endtask

  initial begin
    int ids[5] = '{0, 1, 2, 3, 0};
    logic [31:0] ps[5] = '{2, 4, 8, 16, 2};
    int nr, ng;
    bit any_bad;
    vecs[0] = '{0, 32'd3, 32'd4, 32'd81, 9, 1};
    vecs[1] = '{1, 32'd2, 32'd33, 32'd0, 38, 1};
    vecs[2] = '{3, 32'hFFFF_FFFF, 32'd2, 32'd1, 7, 1};
    vecs[3] = '{2, 32'd5, 32'd0, 32'd1, BYP ? 1 : 5, BYP ? 0 : 1};
    vecs[4] = '{1, 32'd1, 32'd5, 32'd1, BYP ? 1 : 10, BYP ? 0 : 1};
    vecs[5] = '{0, 32'd0, 32'd3, 32'd0, BYP ? 1 : 8, BYP ? 0 : 1};
    vecs[6] = '{2, 32'd7, 32'd3, 32'd343, 8, 1};

    do_reset();
    #1;
    check_zero("reset");
    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'd2, 32'(i + 1));
    nr = 0; ng = 0;
    for (int k = 0; k < 400 && nr < 5; k++) begin
      step();
      #1;
      if (|req_ready && ng < 5) begin
        check("rr_grant", req_ready, 4'b1 << ids[ng]);
        ng++;
      end
      if (rsp_valid) begin
        check("rr_id", rsp_id, ids[nr]);
        check("rr_p", rsp_p, ps[nr]);
        nr++;
        if (nr == 5) req_valid = '0;
      end
    end
    check("rr_count", nr, 5);
    step();
    step();

    set_req(0, 32'd3, 32'd10);
    nr = 0;
    for (int k = 0; k < 50 && nr == 0; k++) begin
      step();
      #1;
      if (exp_enable) nr = 1;
    end
    check("midjob_enable", nr, 1);
    step();
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    #1;
    check_zero("midreset");
    reset_n = 1'b1;
    any_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      if (rsp_valid) any_bad = 1'b1;
    end
    check("no_lost_rsp", any_bad, 1'b0);
    run_job('{2, 32'd7, 32'd2, 32'd49, 7, 1});

    stub = 1'b1;
    do_reset();
    set_req(0, 32'd3, 32'd1);
    nr = 0; ng = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      #1;
      if (|req_ready) nr = 1;
      if (busy) ng = 1;
    end
    check("stub_ready", nr, 0);
    check("stub_busy", ng, 0);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
